// File: rtl/count_updown_mod_if.sv
// Control and status bundle for count_updown_mod: step/clear/load controls,
// mode and terminal value in, registered count and event flags out.
interface count_updown_mod_if #(
    parameter int WIDTH = 8
);
    logic             iEnable;
    logic             iClear;
    logic             iLoad;
    logic [WIDTH-1:0] iData;
    logic             iUp;
    logic             iSat;
    logic [WIDTH-1:0] iMax;
    logic             iFlagClr;
    logic [WIDTH-1:0] oA;
    logic             oTc;
    logic             oOvf;
    logic             oAtMax;

    modport master (
        output iEnable, iClear, iLoad, iData, iUp, iSat, iMax, iFlagClr,
        input  oA, oTc, oOvf, oAtMax
    );

    modport slave (
        input  iEnable, iClear, iLoad, iData, iUp, iSat, iMax, iFlagClr,
        output oA, oTc, oOvf, oAtMax
    );
endinterface

// File: rtl/count_updown_mod.sv
// Up/down modulo counter over 0..iMax with wrap/saturate modes, clear/load,
// a terminal-count pulse and a sticky overflow flag; every output registered.
module count_updown_mod #(
    parameter int WIDTH = 8,
    parameter int DELAY = 1
) (
    input  logic                iClock,
    input  logic                iReset,
    count_updown_mod_if.slave   bus
);

    // DELAY only shaped the register timing of the behavioural model; here it
    // is range-checked alongside WIDTH so bad instantiations fail elaboration.
    generate
        if (WIDTH < 2 || DELAY < 0) begin : gBadParams
            $error("count_updown_mod: WIDTH must be >= 2 and DELAY >= 0");
        end
    endgenerate

    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             atMax;
    logic [WIDTH-1:0] nextCount;
    logic             boundEvent;

    always_comb begin
        nextCount  = count;
        boundEvent = 1'b0;
        if (bus.iClear) begin
            nextCount = '0;
        end else if (bus.iLoad) begin
            nextCount = (bus.iData > bus.iMax) ? bus.iMax : bus.iData;
        end else if (bus.iEnable) begin
            if (bus.iUp) begin
                if (count < bus.iMax) begin
                    nextCount = count + 1'b1;
                end else begin
                    boundEvent = 1'b1;
                    nextCount  = bus.iSat ? bus.iMax : '0;
                end
            // A count left above a lowered iMax is pulled back to the bound.
            end else if (count > bus.iMax) begin
                boundEvent = 1'b1;
                nextCount  = bus.iMax;
            end else if (count == '0) begin
                boundEvent = 1'b1;
                nextCount  = bus.iSat ? '0 : bus.iMax;
            end else begin
                nextCount = count - 1'b1;
            end
        end
    end

    // A bound event in the same cycle as iFlagClr keeps the overflow set.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            atMax <= 1'b0;
        end else begin
            count <= nextCount;
            tc    <= boundEvent;
            ovf   <= boundEvent | (ovf & ~bus.iFlagClr);
            atMax <= (nextCount >= bus.iMax);
        end
    end

    assign bus.oA     = count;
    assign bus.oTc    = tc;
    assign bus.oOvf   = ovf;
    assign bus.oAtMax = atMax;

endmodule
